// File: rtl/id_ex_stage_reg.sv
// rtl/id_ex_stage_reg.sv - ID/EX pipeline register with load-use stall and bubble insertion
// Optional build macro: ID_EX_PERF_CNT_EN adds bubble_cnt/flush_cnt performance counters.
module id_ex_stage_reg #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int ALUC_W = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              validD,
    input  logic [XLEN-1:0]   RD1D,
    input  logic [XLEN-1:0]   RD2D,
    input  logic [XLEN-1:0]   PCD,
    input  logic [XLEN-1:0]   PCPlus4D,
    input  logic [XLEN-1:0]   ImmExtD,
    input  logic [REG_AW-1:0] Rs1D,
    input  logic [REG_AW-1:0] Rs2D,
    input  logic [REG_AW-1:0] RdD,
    input  logic              RegWriteD,
    input  logic              MemWriteD,
    input  logic [1:0]        ResultSrcD,
    input  logic              BranchD,
    input  logic              JumpD,
    input  logic              ALUSrcD,
    input  logic [ALUC_W-1:0] ALUControlD,
    input  logic              FlushE,
    input  logic              HoldE,
    output logic              validE,
    output logic [XLEN-1:0]   RD1E,
    output logic [XLEN-1:0]   RD2E,
    output logic [XLEN-1:0]   PCE,
    output logic [XLEN-1:0]   PCPlus4E,
    output logic [XLEN-1:0]   ImmExtE,
    output logic [REG_AW-1:0] Rs1E,
    output logic [REG_AW-1:0] Rs2E,
    output logic [REG_AW-1:0] RdE,
    output logic              RegWriteE,
    output logic              MemWriteE,
    output logic              BranchE,
    output logic              JumpE,
    output logic              ALUSrcE,
    output logic [1:0]        ResultSrcE,
    output logic [ALUC_W-1:0] ALUControlE,
    output logic              StallF,
    output logic              StallD
`ifdef ID_EX_PERF_CNT_EN
    ,
    output logic [31:0]       bubble_cnt,
    output logic [31:0]       flush_cnt
`endif
);

    typedef struct packed {
        logic              valid;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc4;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [REG_AW-1:0] rd;
        logic              reg_write;
        logic              mem_write;
        logic [1:0]        result_src;
        logic              branch;
        logic              jump;
        logic              alu_src;
        logic [ALUC_W-1:0] alu_ctrl;
    } ex_t;

    ex_t  ex_q, ex_d, dec;
    logic lduse;
    logic stall;

    assign dec = '{valid: validD, rd1: RD1D, rd2: RD2D, pc: PCD, pc4: PCPlus4D,
                   imm: ImmExtD, rs1: Rs1D, rs2: Rs2D, rd: RdD,
                   reg_write: RegWriteD, mem_write: MemWriteD, result_src: ResultSrcD,
                   branch: BranchD, jump: JumpD, alu_src: ALUSrcD, alu_ctrl: ALUControlD};

    // A load in E whose destination feeds the real instruction in D must wait one cycle.
    assign lduse = ex_q.valid && (ex_q.result_src == 2'b01) && (ex_q.rd != '0) && validD
                   && ((ex_q.rd == Rs1D) || (ex_q.rd == Rs2D));
    assign stall = lduse && !FlushE && !HoldE;

    always_comb begin
        ex_d = ex_q;
        if (FlushE) begin
            ex_d = '0;
        end else if (HoldE) begin
            ex_d = ex_q;
        end else if (lduse) begin
            ex_d = '0;
        end else begin
            ex_d = dec;
            if (!validD) begin
                ex_d.valid      = 1'b0;
                ex_d.reg_write  = 1'b0;
                ex_d.mem_write  = 1'b0;
                ex_d.result_src = 2'b00;
                ex_d.branch     = 1'b0;
                ex_d.jump       = 1'b0;
                ex_d.alu_src    = 1'b0;
                ex_d.alu_ctrl   = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign validE      = ex_q.valid;
    assign RD1E        = ex_q.rd1;
    assign RD2E        = ex_q.rd2;
    assign PCE         = ex_q.pc;
    assign PCPlus4E    = ex_q.pc4;
    assign ImmExtE     = ex_q.imm;
    assign Rs1E        = ex_q.rs1;
    assign Rs2E        = ex_q.rs2;
    assign RdE         = ex_q.rd;
    assign RegWriteE   = ex_q.reg_write;
    assign MemWriteE   = ex_q.mem_write;
    assign ResultSrcE  = ex_q.result_src;
    assign BranchE     = ex_q.branch;
    assign JumpE       = ex_q.jump;
    assign ALUSrcE     = ex_q.alu_src;
    assign ALUControlE = ex_q.alu_ctrl;
    assign StallF      = stall;
    assign StallD      = stall;

`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt_q, flush_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bubble_cnt_q <= '0;
            flush_cnt_q  <= '0;
        end else if (!HoldE) begin
            if (stall) begin
                bubble_cnt_q <= bubble_cnt_q + 32'd1;
            end
            if (FlushE) begin
                flush_cnt_q <= flush_cnt_q + 32'd1;
            end
        end
    end

    assign bubble_cnt = bubble_cnt_q;
    assign flush_cnt  = flush_cnt_q;
`endif

endmodule

// File: tb/tb_id_ex_stage_reg.sv
// tb/tb_id_ex_stage_reg.sv - self-checking bench for id_ex_stage_reg
module tb_id_ex_stage_reg;

    typedef struct packed {
        logic        v;
        logic [31:0] rd1, rd2, pc, pc4, imm;
        logic [4:0]  rs1, rs2, rd;
        logic        rw, mw;
        logic [1:0]  rs;
        logic        br, jp, as;
        logic [2:0]  alu;
    } e_t;

    logic clk = 1'b0;
    logic rst_n;
    logic flush, hold;
    e_t   din, obs_e, exp_e;
    e_t   sb[$];
    int   errors = 0;
    int   checks = 0;
    int   exp_bub = 0;
    int   exp_fl  = 0;

    logic        validE, RegWriteE, MemWriteE, BranchE, JumpE, ALUSrcE, StallF, StallD;
    logic [31:0] RD1E, RD2E, PCE, PCPlus4E, ImmExtE;
    logic [4:0]  Rs1E, Rs2E, RdE;
    logic [1:0]  ResultSrcE;
    logic [2:0]  ALUControlE;
`ifdef ID_EX_PERF_CNT_EN
    logic [31:0] bubble_cnt, flush_cnt;
`endif

    always #5 clk = ~clk;

    id_ex_stage_reg dut (
        .clk(clk), .rst_n(rst_n), .validD(din.v),
        .RD1D(din.rd1), .RD2D(din.rd2), .PCD(din.pc), .PCPlus4D(din.pc4), .ImmExtD(din.imm),
        .Rs1D(din.rs1), .Rs2D(din.rs2), .RdD(din.rd),
        .RegWriteD(din.rw), .MemWriteD(din.mw), .ResultSrcD(din.rs),
        .BranchD(din.br), .JumpD(din.jp), .ALUSrcD(din.as), .ALUControlD(din.alu),
        .FlushE(flush), .HoldE(hold),
        .validE(validE), .RD1E(RD1E), .RD2E(RD2E), .PCE(PCE), .PCPlus4E(PCPlus4E),
        .ImmExtE(ImmExtE), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
        .RegWriteE(RegWriteE), .MemWriteE(MemWriteE), .BranchE(BranchE), .JumpE(JumpE),
        .ALUSrcE(ALUSrcE), .ResultSrcE(ResultSrcE), .ALUControlE(ALUControlE),
        .StallF(StallF), .StallD(StallD)
`ifdef ID_EX_PERF_CNT_EN
        , .bubble_cnt(bubble_cnt), .flush_cnt(flush_cnt)
`endif
    );

    assign obs_e = {validE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE, Rs1E, Rs2E, RdE,
                    RegWriteE, MemWriteE, ResultSrcE, BranchE, JumpE, ALUSrcE, ALUControlE};

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_cnt(input string tag);
`ifdef ID_EX_PERF_CNT_EN
        chk({tag, "/bubble_cnt"}, 256'(bubble_cnt), 256'(exp_bub));
        chk({tag, "/flush_cnt"}, 256'(flush_cnt), 256'(exp_fl));
`endif
    endtask

    // Reference model: decide stall and next E contents, queue the expectation, clock, compare.
    task automatic step(input string tag);
        e_t   n, got;
        logic ld, st;
        #1;
        ld = exp_e.v && exp_e.rs == 2'b01 && exp_e.rd != 5'd0 && din.v
             && (exp_e.rd == din.rs1 || exp_e.rd == din.rs2);
        st = ld && !flush && !hold;
        chk({tag, "/stall"}, 256'({StallF, StallD}), 256'({st, st}));
        if (flush) n = '0;
        else if (hold) n = exp_e;
        else if (ld) n = '0;
        else begin
            n = din;
            if (!din.v) begin
                n.rw = 0; n.mw = 0; n.rs = 0; n.br = 0; n.jp = 0; n.as = 0; n.alu = 0;
            end
        end
        sb.push_back(n);
        if (!hold) begin
            if (st) exp_bub++;
            if (flush) exp_fl++;
        end
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "/sb_empty"}, 256'(1), 256'(0));
        end else begin
            got = sb.pop_front();
            chk({tag, "/E"}, 256'(obs_e), 256'(got));
            exp_e = got;
        end
        chk_cnt(tag);
    endtask

    function automatic e_t instr(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                                 input logic [1:0] rs, input logic rw, input logic mw);
        e_t x;
        x     = '0;
        x.v   = 1'b1;
        x.rd1 = $urandom; x.rd2 = $urandom; x.pc = $urandom; x.imm = $urandom;
        x.pc4 = x.pc + 32'd4;
        x.rs1 = rs1; x.rs2 = rs2; x.rd = rd;
        x.rs  = rs; x.rw = rw; x.mw = mw;
        x.alu = 3'($urandom_range(0, 7));
        x.as  = 1'($urandom_range(0, 1));
        return x;
    endfunction

    initial begin
        rst_n = 1'b0; flush = 1'b0; hold = 1'b0; din = '0; exp_e = '0;
        #3;
        chk("reset/E", 256'(obs_e), 256'(0));
        chk("reset/stall", 256'({StallF, StallD}), 256'(0));
        chk_cnt("reset");
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Pass-through
        din = instr(5'd1, 5'd2, 5'd5, 2'b00, 1'b1, 1'b0);
        din.rd1 = 32'h1234_5678;
        step("pass");
        chk("pass/RdE", 256'(RdE), 256'(5));
        chk("pass/RD1E", 256'(RD1E), 256'(32'h1234_5678));
        chk("pass/RegWriteE", 256'(RegWriteE), 256'(1));
        chk("pass/validE", 256'(validE), 256'(1));

        // validD=0 gates all control
        din = instr(5'd1, 5'd2, 5'd3, 2'b10, 1'b1, 1'b1);
        din.v = 1'b0; din.br = 1'b1; din.jp = 1'b1;
        step("invalid");
        chk("invalid/ctl", 256'({validE, RegWriteE, MemWriteE, BranchE, JumpE, ResultSrcE}), 256'(0));

        // Load-use: lw x6 then add using x6 as rs2
        din = instr(5'd2, 5'd0, 5'd6, 2'b01, 1'b1, 1'b0);
        step("lw6");
        din = instr(5'd7, 5'd6, 5'd8, 2'b00, 1'b1, 1'b0);
        #1;
        chk("lduse/StallF", 256'(StallF), 256'(1));
        chk("lduse/StallD", 256'(StallD), 256'(1));
        step("lduse_bubble");
        chk("lduse/bubble", 256'(validE), 256'(0));
        step("lduse_go");
        chk("lduse/Rs2E", 256'(Rs2E), 256'(6));
        chk("lduse/validE", 256'(validE), 256'(1));

        // Load to x0 never stalls
        din = instr(5'd1, 5'd1, 5'd0, 2'b01, 1'b1, 1'b0);
        step("lw0");
        din = instr(5'd0, 5'd0, 5'd9, 2'b00, 1'b1, 1'b0);
        #1;
        chk("x0/StallF", 256'(StallF), 256'(0));
        step("x0_go");
        chk("x0/validE", 256'(validE), 256'(1));

        // Flush beats load-use
        din = instr(5'd1, 5'd1, 5'd6, 2'b01, 1'b1, 1'b0);
        step("lw6b");
        din = instr(5'd6, 5'd3, 5'd4, 2'b00, 1'b1, 1'b1);
        flush = 1'b1;
        #1;
        chk("flush/StallF", 256'(StallF), 256'(0));
        step("flush");
        chk("flush/ctl", 256'({validE, RegWriteE, MemWriteE}), 256'(0));
        flush = 1'b0;

        // Hold with pending load-use: E frozen, no stall, then stall once hold drops
        din = instr(5'd1, 5'd2, 5'd9, 2'b01, 1'b1, 1'b0);
        step("lw9");
        hold = 1'b1;
        for (int i = 0; i < 3; i++) begin
            din = instr(5'd9, 5'(i), 5'(10 + i), 2'b00, 1'b1, 1'b0);
            step("hold");
            chk("hold/RdE", 256'(RdE), 256'(9));
            chk("hold/ResultSrcE", 256'(ResultSrcE), 256'(1));
        end
        hold = 1'b0;
        #1;
        chk("hold_release/StallF", 256'(StallF), 256'(1));
        step("hold_release");

        // Randomised traffic against the model
        for (int i = 0; i < 60; i++) begin
            din = instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                        5'($urandom_range(0, 3)), 2'($urandom_range(0, 2)),
                        1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            din.v = ($urandom_range(0, 5) != 0);
            flush = ($urandom_range(0, 7) == 0);
            hold  = ($urandom_range(0, 5) == 0);
            step("rand");
        end
        flush = 1'b0; hold = 1'b0;

        // Asynchronous reset in the middle of a stall
        din = instr(5'd1, 5'd2, 5'd3, 2'b01, 1'b1, 1'b0);
        step("lw3");
        din = instr(5'd3, 5'd1, 5'd4, 2'b00, 1'b1, 1'b0);
        #1;
        chk("midrst/pre_stall", 256'(StallF), 256'(1));
        rst_n = 1'b0;
        #1;
        chk("midrst/E", 256'(obs_e), 256'(0));
        chk("midrst/stall", 256'({StallF, StallD}), 256'(0));
        exp_bub = 0; exp_fl = 0;
        chk_cnt("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
